// File: rtl/mux2_result_checker_pkg.sv
// Shared constants for the 2:1 mux result checker: FSM encoding and default sizing.
// Imported by the checker top and available to any other mux checker in the slice.
package mux2_result_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } chk_state_e;

   localparam int N_SAMPLES_DEFAULT = 8;
   localparam int CNT_W_DEFAULT     = 8;

   // Packs a captured sample in the order reported on first_err_vec.
   function automatic logic [3:0] pack_vec(input logic x1, input logic x2,
                                           input logic s, input logic f);
      return {x1, x2, s, f};
   endfunction

endpackage

// File: rtl/mux2_ref_model.sv
// Combinational golden model of a 2:1 mux; reusable by any checker that needs exp.
module mux2_ref_model (
   input  logic x1,
   input  logic x2,
   input  logic s,
   output logic exp
);

   assign exp = (~s & x1) | (s & x2);

endmodule

// File: rtl/mux2_result_checker.sv
// Runs N_SAMPLES valid samples of a mux under test against mux2_ref_model and
// reports sample/error counts plus the first failing vector. All outputs are registered.
module mux2_result_checker
   import mux2_result_checker_pkg::*;
#(
   parameter int N_SAMPLES = N_SAMPLES_DEFAULT,
   parameter int CNT_W     = CNT_W_DEFAULT
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             start,
   input  logic             valid,
   input  logic             x1,
   input  logic             x2,
   input  logic             s,
   input  logic             f,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [3:0]       first_err_vec
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   chk_state_e state;
   logic       err_captured;
   logic       exp;
   logic       mismatch;

   mux2_ref_model u_ref (
      .x1  (x1),
      .x2  (x2),
      .s   (s),
      .exp (exp)
   );

   assign mismatch = (f != exp);

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would let err_count see this cycle's update.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state         <= ST_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         sample_count  <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         first_err_vec <= '0;
         err_captured  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               // valid is ignored here; only start leaves these states
               if (start) begin
                  state         <= ST_RUN;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  sample_count  <= '0;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  first_err_vec <= '0;
                  err_captured  <= 1'b0;
               end
            end

            ST_RUN: begin
               if (valid) begin
                  sample_count <= sample_count + 1'b1;
                  if (mismatch) begin
                     if (err_count != CNT_MAX) begin
                        err_count <= err_count + 1'b1;
                     end
                     if (!err_captured) begin
                        err_captured  <= 1'b1;
                        first_err_idx <= sample_count;
                        first_err_vec <= pack_vec(x1, x2, s, f);
                     end
                  end
                  // pass must account for the final sample's own result
                  if (sample_count == LAST_IDX) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_count == '0) && !mismatch;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux2_result_checker.sv
// Directed bench for mux2_result_checker: clean, faulty, gapped, reset-abort and restart runs.
module tb_mux2_result_checker;

   localparam int CNT_W = 8;

   logic             Clock = 1'b0;
   logic             Resetn;
   logic             start, valid, x1, x2, s, f;
   logic             busy, done, pass;
   logic [CNT_W-1:0] sample_count, err_count, first_err_idx;
   logic [3:0]       first_err_vec;

   int n_checks = 0;
   int n_fail   = 0;

   // sample 5 is {x1,x2,s}=100 and sample 2 is 010
   logic [2:0] vec_tbl [8] = '{3'b000, 3'b001, 3'b010, 3'b011,
                               3'b101, 3'b100, 3'b110, 3'b111};
   int gap_tbl [8] = '{1, 2, 1, 2, 1, 2, 3, 0};

   mux2_result_checker #(.N_SAMPLES(8), .CNT_W(CNT_W)) dut (
      .Clock         (Clock),
      .Resetn        (Resetn),
      .start         (start),
      .valid         (valid),
      .x1            (x1),
      .x2            (x2),
      .s             (s),
      .f             (f),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .sample_count  (sample_count),
      .err_count     (err_count),
      .first_err_idx (first_err_idx),
      .first_err_vec (first_err_vec)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      @(posedge Clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic b, input logic d, input logic p,
                            input int sc, input int ec, input int idx, input logic [3:0] vec);
      check({tag, ".busy"}, 32'(busy), 32'(b));
      check({tag, ".done"}, 32'(done), 32'(d));
      check({tag, ".pass"}, 32'(pass), 32'(p));
      check({tag, ".sample_count"}, 32'(sample_count), 32'(sc));
      check({tag, ".err_count"}, 32'(err_count), 32'(ec));
      check({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(idx));
      check({tag, ".first_err_vec"}, 32'(first_err_vec), 32'(vec));
   endtask

   // Pulses start (with valid also high, which must be ignored) and checks the cleared run state.
   task automatic start_run(input string tag);
      start = 1'b1;
      valid = 1'b1;
      {x1, x2, s, f} = 4'b1001;
      cycle();
      start = 1'b0;
      valid = 1'b0;
      check_all({tag, ".start"}, 1'b1, 1'b0, 1'b0, 0, 0, 0, 4'b0000);
   endtask

   // Feeds n samples from vec_tbl; mask bit i inverts f on sample i.
   task automatic feed(input string tag, input int n, input logic [7:0] mask, input bit gapped);
      logic ex;
      for (int i = 0; i < n; i++) begin
         {x1, x2, s} = vec_tbl[i];
         ex = s ? x2 : x1;
         f = ex ^ mask[i];
         valid = 1'b1;
         cycle();
         valid = 1'b0;
         check($sformatf("%s.sc_after_%0d", tag, i), 32'(sample_count), 32'(i + 1));
         if (gapped) begin
            for (int g = 0; g < gap_tbl[i]; g++) begin
               start = (i == 3 && g == 0);
               {x1, x2, s, f} = 4'b1000;
               cycle();
               start = 1'b0;
            end
            if (i == 3) begin
               check({tag, ".mid_start_busy"}, 32'(busy), 32'd1);
               check({tag, ".mid_start_sc"}, 32'(sample_count), 32'd4);
            end
            if (i == 6) check({tag, ".not_done_yet"}, 32'(done), 32'd0);
         end
      end
   endtask

   initial begin
      Resetn = 1'b0;
      start  = 1'b0;
      valid  = 1'b0;
      {x1, x2, s, f} = 4'b0000;
      #3;
      check_all("reset", 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'b0000);
      cycle();
      cycle();
      Resetn = 1'b1;
      cycle();
      check_all("idle", 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'b0000);

      // Clean run over all select/data combinations
      start_run("clean");
      feed("clean", 8, 8'h00, 1'b0);
      check_all("clean.end", 1'b0, 1'b1, 1'b1, 8, 0, 0, 4'b0000);

      // valid in DONE is ignored and results hold
      valid = 1'b1;
      {x1, x2, s, f} = 4'b1000;
      cycle();
      cycle();
      valid = 1'b0;
      check_all("done_hold", 1'b0, 1'b1, 1'b1, 8, 0, 0, 4'b0000);

      // Restart from DONE, single fault on sample 5
      start_run("fault5");
      feed("fault5", 8, 8'b0010_0000, 1'b0);
      check_all("fault5.end", 1'b0, 1'b1, 1'b0, 8, 1, 5, 4'b1000);

      // Faults on samples 2, 3, 7; capture stays at sample 2
      start_run("multi");
      feed("multi", 8, 8'b1000_1100, 1'b0);
      check_all("multi.end", 1'b0, 1'b1, 1'b0, 8, 3, 2, 4'b0101);

      // Gapped valid over 20 cycles with a start pulse mid-run
      start_run("gapped");
      feed("gapped", 8, 8'h00, 1'b1);
      check_all("gapped.end", 1'b0, 1'b1, 1'b1, 8, 0, 0, 4'b0000);

      // Reset mid-run after 4 samples (one error captured), asynchronous
      start_run("abort");
      feed("abort", 4, 8'b0000_0010, 1'b0);
      check_all("abort.mid", 1'b1, 1'b0, 1'b0, 4, 1, 1, 4'b0011);
      #2;
      Resetn = 1'b0;
      #1;
      check_all("abort.reset", 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'b0000);
      #1;
      Resetn = 1'b1;
      cycle();
      check_all("abort.idle", 1'b0, 1'b0, 1'b0, 0, 0, 0, 4'b0000);

      // Fresh full run after the abort
      start_run("rerun");
      feed("rerun", 8, 8'h00, 1'b0);
      check_all("rerun.end", 1'b0, 1'b1, 1'b1, 8, 0, 0, 4'b0000);

      // Second clean run straight from DONE
      start_run("restart");
      feed("restart", 8, 8'h00, 1'b0);
      check_all("restart.end", 1'b0, 1'b1, 1'b1, 8, 0, 0, 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mux2_result_checker.md
MUX2_RESULT_CHECKER -- requirements
Module: mux2_result_checker

Interface
REQ-001 Parameter N_SAMPLES, default 8, number of valid samples per check run (1..255).
REQ-002 Parameter CNT_W, default 8, width of all counters; N_SAMPLES SHALL fit in CNT_W bits.
REQ-003 Port Clock  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-004 Port Resetn  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  begins a run; level sampled on the clock edge.
REQ-006 Port valid  input  1  marks x1/x2/s/f as a sample to check this cycle.
REQ-007 Port x1  input  1  mux data input 0, as driven into the mux under test.
REQ-008 Port x2  input  1  mux data input 1, as driven into the mux under test.
REQ-009 Port s  input  1  mux select, as driven into the mux under test.
REQ-010 Port f  input  1  output of the mux under test.
REQ-011 Port busy  output  1  high while in RUN.
REQ-012 Port done  output  1  high while in DONE.
REQ-013 Port pass  output  1  high in DONE when err_count is 0; 0 in all other states.
REQ-014 Port sample_count  output  CNT_W  valid samples checked in the current or last run.
REQ-015 Port err_count  output  CNT_W  mismatches in the current or last run.
REQ-016 Port first_err_idx  output  CNT_W  sample_count value at the first mismatch.
REQ-017 Port first_err_vec  output  4  {x1,x2,s,f} captured at the first mismatch.

Function
REQ-018 Expected output SHALL be exp = (~s & x1) | (s & x2).
REQ-019 FSM states SHALL be IDLE, RUN and DONE.
REQ-020 IDLE -> RUN on start=1. On that edge, sample_count, err_count, first_err_idx and first_err_vec clear to 0, and the error-captured flag clears.
REQ-021 In RUN, on each edge with valid=1, sample_count increments by 1. err_count increments by 1 if f != exp.
REQ-022 On the first mismatch of a run, first_err_idx takes the pre-increment sample_count and first_err_vec takes {x1,x2,s,f}. Later mismatches SHALL NOT overwrite these values.
REQ-023 Latency: counter and capture updates SHALL be visible one cycle after the sampled edge. No combinational path SHALL exist from inputs to outputs.
REQ-024 RUN -> DONE on the edge that accepts the N_SAMPLES-th valid sample. done and pass SHALL be valid the following cycle.
REQ-025 start while in RUN SHALL be ignored, and the run SHALL continue.
REQ-026 valid=0 in RUN SHALL leave all counters unchanged. Gaps of any length SHALL be allowed.
REQ-027 valid while in IDLE or DONE SHALL be ignored.
REQ-028 DONE SHALL hold all results until start=1. start=1 in DONE SHALL go directly to RUN with the same clearing as REQ-020.
REQ-029 err_count SHALL saturate at all-ones and never wrap.

Reset
REQ-030 Resetn=0 SHALL immediately force state IDLE, busy=0, done=0, pass=0, and all counts and captures to 0, independent of Clock.
REQ-031 Reset asserted mid-RUN SHALL abandon the run with no partial results retained.
REQ-032 After Resetn deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Structure
REQ-033 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the N_SAMPLES default SHALL live in the shared mux constants package/include.
REQ-034 The expected-value equation SHALL be a sub-module, mux2_ref_model (x1, x2, s -> exp). It SHALL be combinational and reusable by other checkers.

Verification
REQ-035 Correct mux: reset, start, then 8 valid samples covering all {x1,x2,s} combinations with f=exp -> done=1, pass=1, sample_count=8, err_count=0.
REQ-036 Faulty f: f forced to 0 on sample 5 (x1=1, x2=0, s=0) -> err_count=1, first_err_idx=5, first_err_vec=4'b1000, pass=0.
REQ-037 Multiple errors: mismatches on samples 2, 3 and 7 -> err_count=3, first_err_idx=2, with captures from sample 2 unchanged.
REQ-038 Gapped valid, 8 samples spread over 20 cycles, plus start pulsed mid-run -> run not restarted, done after the 8th sample, sample_count=8.
REQ-039 Resetn pulsed low mid-RUN after 4 samples -> all outputs 0 without a clock edge. A new start then runs a full 8 samples from 0.
REQ-040 Restart from DONE with start=1 -> next cycle busy=1, done=0, counts=0, then a second clean run -> pass=1.
